// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Defining UART_TX_BREAK_EN adds the BREAK state used by the line-break feature.
package uart_pkg;

  localparam int unsigned MIN_DATA_BITS = 5;
  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
`ifdef UART_TX_BREAK_EN
    , BREAK
`endif
  } state_t;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                 input logic [3:0] max_bits);
    if (req < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (req > max_bits) return max_bits;
    return req;
  endfunction

  // XOR of the low n bits, inverted for odd parity.
  function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data,
                                     input logic [3:0] n, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < int'(MAX_DATA_BITS); i++) begin
      if (i < int'(n)) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Bus-side write port of the UART transmitter: byte strobe/data in, FIFO status out.
interface uart_tx_cfg_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  tx_wen;
  logic [DATA_WIDTH-1:0] din;
  logic                  full;
  logic                  empty;

  modport master (output tx_wen, din, input full, empty);
  modport slave  (input tx_wen, din, output full, empty);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: runs 0..div_i-1 and flags the last clock of each period.
module uart_baud_tick #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);
  logic [DIV_WIDTH-1:0] cnt_d, cnt_q;

  assign tick_o = (cnt_q == div_i - DIV_WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wrap_around_fifo.sv
// Power-of-two FIFO with wrap-bit pointers; SHOW_AHEAD=1 presents the head word combinationally.
module wrap_around_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter bit          SHOW_AHEAD = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wen_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             ren_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_d, wptr_q, rptr_d, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // A write while full is dropped even if a read frees a slot in the same cycle.
  assign do_wr   = wen_i && !full_o;
  assign do_rd   = ren_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q + (AW+1)'(do_wr);
    rptr_d = rptr_q + (AW+1)'(do_rd);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

  if (SHOW_AHEAD) begin : g_show_ahead
    assign dout_o = mem_q[rptr_q[AW-1:0]];
  end else begin : g_registered
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk_i) begin
      if (do_rd) dout_q <= mem_q[rptr_q[AW-1:0]];
    end
    assign dout_o = dout_q;
  end
endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (baud, 5..DATA_WIDTH bits, parity, 1/2 stop) with TX FIFO.
// Optional macro UART_TX_BREAK_EN adds the break_i input and the BREAK state.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tx_en_i,
  input  logic [DIV_WIDTH-1:0] baud_div_i,
  input  logic [3:0]           data_bits_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 stop2_i,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_i,
`endif
  uart_tx_cfg_if.slave         bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tx_bit_o
);
  state_t                   state_d, state_q;
  logic [DATA_WIDTH-1:0]    shift_d, shift_q, head;
  logic [DIV_WIDTH-1:0]     div_d, div_q, div_eff;
  logic [3:0]               nbits_d, nbits_q, bit_cnt_d, bit_cnt_q;
  logic                     par_en_d, par_en_q, par_bit_d, par_bit_q;
  logic                     stop2_d, stop2_q, tx_bit_d, tx_bit_q;
  logic                     clr, tick, frame_end, can_pop, start_frame;
  logic [MAX_DATA_BITS-1:0] head_ext;

  wrap_around_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH), .SHOW_AHEAD(1'b1)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wen_i   (bus.tx_wen),
    .din_i   (bus.din),
    .ren_i   (start_frame),
    .dout_o  (head),
    .full_o  (bus.full),
    .empty_o (bus.empty)
  );

  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .div_i  (div_q),
    .tick_o (tick)
  );

  assign div_eff   = (baud_div_i == '0) ? DIV_WIDTH'(1) : baud_div_i;
  assign head_ext  = MAX_DATA_BITS'(head);
  assign can_pop   = tx_en_i && !bus.empty;
  // bit_cnt_q[0] marks the second stop bit when two are configured.
  assign frame_end = (state_q == STOP) && tick && (!stop2_q || bit_cnt_q[0]);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    div_d       = div_q;
    nbits_d     = nbits_q;
    bit_cnt_d   = bit_cnt_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    stop2_d     = stop2_q;
    tx_bit_d    = tx_bit_q;
    clr         = 1'b0;
    start_frame = 1'b0;
    case (state_q)
      IDLE: begin
        clr      = 1'b1;
        tx_bit_d = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (break_i) begin
          state_d   = BREAK;
          tx_bit_d  = 1'b0;
          bit_cnt_d = '0;
        end else
`endif
        if (can_pop) start_frame = 1'b1;
      end
      START: if (tick) begin
        state_d   = DATA;
        tx_bit_d  = shift_q[0];
        shift_d   = shift_q >> 1;
        bit_cnt_d = '0;
      end
      DATA: if (tick) begin
        if (bit_cnt_q == nbits_q - 4'd1) begin
          state_d   = par_en_q ? PARITY : STOP;
          tx_bit_d  = par_en_q ? par_bit_q : 1'b1;
          bit_cnt_d = '0;
        end else begin
          tx_bit_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      PARITY: if (tick) begin
        state_d   = STOP;
        tx_bit_d  = 1'b1;
        bit_cnt_d = '0;
      end
      STOP: if (tick) begin
        if (frame_end) begin
          state_d = IDLE;
          if (can_pop) start_frame = 1'b1;
        end else begin
          bit_cnt_d = 4'd1;
        end
      end
`ifdef UART_TX_BREAK_EN
      // bit_cnt_q==0: line held low; ==1: one high bit period after release.
      BREAK: begin
        if (bit_cnt_q == '0) begin
          tx_bit_d = 1'b0;
          if (!break_i) begin
            bit_cnt_d = 4'd1;
            tx_bit_d  = 1'b1;
            div_d     = div_eff;
            clr       = 1'b1;
          end
        end else if (tick) begin
          state_d = IDLE;
          if (can_pop) start_frame = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      state_d   = START;
      clr       = 1'b1;
      tx_bit_d  = 1'b0;
      shift_d   = head;
      nbits_d   = clamp_data_bits(data_bits_i, 4'(DATA_WIDTH));
      par_en_d  = parity_en_i;
      par_bit_d = parity_of(head_ext, clamp_data_bits(data_bits_i, 4'(DATA_WIDTH)), parity_odd_i);
      stop2_d   = stop2_i;
      div_d     = div_eff;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      div_q     <= DIV_WIDTH'(1);
      nbits_q   <= 4'(MIN_DATA_BITS);
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_bit_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      nbits_q   <= nbits_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_bit_q  <= tx_bit_d;
    end
  end

  assign tx_bit_o = tx_bit_q;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = frame_end;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed scenarios plus randomized frames against a line-level model.
module tb_uart_tx_cfg;
  localparam int DW   = 8;
  localparam int DEP  = 16;
  localparam int DIVW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tx_en = 1'b0;
  logic [DIVW-1:0] baud_div = 16'd4;
  logic [3:0]      data_bits = 4'd8;
  logic            parity_en = 1'b0;
  logic            parity_odd = 1'b0;
  logic            stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic            brk = 1'b0;
`endif
  logic            busy, done, txb;

  uart_tx_cfg_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .DIV_WIDTH(DIVW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tx_en_i      (tx_en),
    .baud_div_i   (baud_div),
    .data_bits_i  (data_bits),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .stop2_i      (stop2),
`ifdef UART_TX_BREAK_EN
    .break_i      (brk),
`endif
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .tx_bit_o     (txb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit exp_tx[$];
  bit exp_done[$];

  // Expected per-clock line level and done flag for one frame, straight from the frame format.
  task automatic model_frame(input logic [7:0] data, input int div, input int nb,
                             input bit pen, input bit podd, input bit s2);
    int d, n;
    bit p;
    bit bits[$];
    d = (div == 0) ? 1 : div;
    n = (nb < 5) ? 5 : ((nb > DW) ? DW : nb);
    p = podd;
    bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      bits.push_back(data[i]);
      p = p ^ data[i];
    end
    if (pen) bits.push_back(p);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < d; c++) begin
        exp_tx.push_back(bits[b]);
        exp_done.push_back((b == bits.size() - 1) && (c == d - 1));
      end
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    bus.tx_wen = 1'b1;
    bus.din    = d;
    @(negedge clk);
    bus.tx_wen = 1'b0;
  endtask

  task automatic set_cfg(input int div, input int nb, input bit pen, input bit podd, input bit s2);
    baud_div   = DIVW'(div);
    data_bits  = 4'(nb);
    parity_en  = pen;
    parity_odd = podd;
    stop2      = s2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (txb !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", txb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single frame: write, enable for exactly one pop, compare every clock of the frame.
  task automatic one_frame(input string name, input logic [7:0] d, input int div, input int nb,
                           input bit pen, input bit podd, input bit s2, input bit scramble);
    exp_tx.delete();
    exp_done.delete();
    set_cfg(div, nb, pen, podd, s2);
    model_frame(d, div, nb, pen, podd, s2);
    write_byte(d);
    tx_en = 1'b1;
    for (int k = 0; k < exp_tx.size(); k++) begin
      @(negedge clk);
      if (k == 0) begin
        tx_en = 1'b0;
        if (scramble) set_cfg($urandom_range(0, 7), $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      checks++; if (txb !== exp_tx[k]) begin errors++; $display("FAIL %s tx cycle %0d got %b want %b", name, k + 1, txb, exp_tx[k]); end
      checks++; if (done !== exp_done[k]) begin errors++; $display("FAIL %s done cycle %0d got %b want %b", name, k + 1, done, exp_done[k]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy cycle %0d got %b want 1", name, k + 1, busy); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_after got %b want 0", name, busy); end
    checks++; if (txb !== 1'b1) begin errors++; $display("FAIL %s idle_line got %b want 1", name, txb); end
  endtask

  task automatic test_8n1();
    one_frame("8n1_a5", 8'hA5, 4, 8, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    one_frame("7e2_55", 8'h55, 3, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    one_frame("5o1_1f", 8'h1F, 2, 5, 1'b1, 1'b1, 1'b0, 1'b0);
    one_frame("5o1_1e", 8'h1E, 2, 5, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 12; f++)
      one_frame("random", 8'($urandom), $urandom_range(0, 5), $urandom_range(0, 15),
                1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    int ndone;
    exp_tx.delete();
    exp_done.delete();
    tx_en = 1'b0;
    set_cfg(2, 8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      if (i < 16) model_frame(d, 2, 8, 1'b0, 1'b0, 1'b0);
      write_byte(d);
      checks++;
      if (bus.full !== (i >= 15)) begin errors++; $display("FAIL fifo_full after write %0d got %b want %b", i + 1, bus.full, (i >= 15)); end
    end
    tx_en = 1'b1;
    ndone = 0;
    for (int k = 0; k < exp_tx.size(); k++) begin
      @(negedge clk);
      if (done) ndone++;
      checks++; if (txb !== exp_tx[k]) begin errors++; $display("FAIL b2b tx cycle %0d got %b want %b", k + 1, txb, exp_tx[k]); end
      checks++; if (done !== exp_done[k]) begin errors++; $display("FAIL b2b done cycle %0d got %b want %b", k + 1, done, exp_done[k]); end
    end
    checks++; if (ndone != 16) begin errors++; $display("FAIL b2b frame_count got %0d want 16", ndone); end
    @(negedge clk);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b empty_end got %b want 1", bus.empty); end
    for (int k = 0; k < 10; k++) begin
      checks++; if (busy !== 1'b0 || txb !== 1'b1) begin errors++; $display("FAIL b2b idle_after busy=%b tx=%b want busy 0 tx 1", busy, txb); end
      @(negedge clk);
    end
    tx_en = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    exp_tx.delete();
    exp_done.delete();
    set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
    model_frame(8'h00, 4, 8, 1'b0, 1'b0, 1'b0);
    write_byte(8'h00);
    write_byte(8'h00);
    tx_en = 1'b1;
    // start bit plus data bits 0..2, then into data bit 3
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      checks++; if (txb !== exp_tx[k]) begin errors++; $display("FAIL rstmid tx cycle %0d got %b want %b", k + 1, txb, exp_tx[k]); end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (txb !== 1'b1) begin errors++; $display("FAIL rstmid tx_in_reset got %b want 1", txb); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rstmid empty_in_reset got %b want 1", bus.empty); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy_in_reset got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++; if (txb !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rstmid residual cycle %0d tx=%b busy=%b want tx 1 busy 0", k, txb, busy); end
    end
    tx_en = 1'b0;
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    exp_tx.delete();
    exp_done.delete();
    set_cfg(4, 8, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 50; k++) begin exp_tx.push_back(1'b0); exp_done.push_back(1'b0); end
    for (int k = 0; k < 4; k++) begin exp_tx.push_back(1'b1); exp_done.push_back(1'b0); end
    model_frame(8'h3C, 4, 8, 1'b0, 1'b0, 1'b0);
    write_byte(8'h3C);
    brk   = 1'b1;
    tx_en = 1'b1;
    for (int k = 0; k < exp_tx.size(); k++) begin
      @(negedge clk);
      checks++; if (txb !== exp_tx[k]) begin errors++; $display("FAIL break tx cycle %0d got %b want %b", k + 1, txb, exp_tx[k]); end
      checks++; if (done !== exp_done[k]) begin errors++; $display("FAIL break done cycle %0d got %b want %b", k + 1, done, exp_done[k]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break busy cycle %0d got %b want 1", k + 1, busy); end
      if (k == 49) brk = 1'b0;
      if (k == 54) tx_en = 1'b0;
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break busy_after got %b want 0", busy); end
  endtask
`endif

  initial begin
    bus.tx_wen = 1'b0;
    bus.din    = '0;
    test_reset();
    test_8n1();
    test_parity();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
